// File: rtl/sponge_absorb.sv
// Sponge absorb phase: XORs message blocks into the rate, applies pad10*1 on
// the last block and runs an external permutation after every absorbed block.
// Optional macro ABSORB_BLK_COUNT_EN builds a saturating absorbed-block counter.
module sponge_absorb #(
  parameter int unsigned CWIDTH = 320,
  parameter int unsigned RWIDTH = 32,
  localparam int unsigned LENW = $clog2(RWIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RWIDTH-1:0] init_r,
  input  logic [CWIDTH-1:0] init_c,
  input  logic [RWIDTH-1:0] msg_data,
  input  logic              msg_valid,
  input  logic              msg_last,
  input  logic [LENW-1:0]   msg_len,
  output logic              msg_ready,
  output logic              perm_req,
  output logic [RWIDTH-1:0] perm_r_in,
  output logic [CWIDTH-1:0] perm_c_in,
  input  logic [RWIDTH-1:0] perm_r_out,
  input  logic [CWIDTH-1:0] perm_c_out,
  input  logic              perm_done,
  output logic [RWIDTH-1:0] r_out,
  output logic [CWIDTH-1:0] c_out,
  output logic              absorb_done,
  output logic [15:0]       blk_count
);

  typedef enum logic [2:0] {StIdle, StAbsorb, StPerm, StPad, StDone} state_e;

  state_e            state_q, state_d;
  logic [RWIDTH-1:0] r_q, r_d;
  logic [CWIDTH-1:0] c_q, c_d;
  logic              last_q, last_d;
  // An extra padding-only block is owed; pend_full selects 10..01 over 0..01.
  logic              pend_q, pend_d;
  logic              pend_full_q, pend_full_d;

  int                len_int;
  logic              len_full;
  logic              len_tight;
  logic [RWIDTH-1:0] pad_blk;
  logic [RWIDTH-1:0] extra_blk;

  assign len_int   = int'(msg_len);
  assign len_full  = (len_int >= int'(RWIDTH));
  assign len_tight = (len_int == int'(RWIDTH) - 1);
  assign extra_blk = {pend_full_q, {(RWIDTH - 2){1'b0}}, 1'b1};

  // Padded last block: keep the top msg_len data bits, set the first pad bit
  // just below them, and the closing pad bit at bit 0 unless the block is full.
  always_comb begin
    pad_blk = '0;
    for (int i = 0; i < int'(RWIDTH); i++) begin
      pad_blk[i] = (msg_data[i] & (i >= int'(RWIDTH) - len_int)) |
                   (i == int'(RWIDTH) - 1 - len_int);
    end
    pad_blk[0] = pad_blk[0] | !len_full;
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    last_d      = last_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    msg_ready   = 1'b0;
    perm_req    = 1'b0;
    absorb_done = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        absorb_done = (state_q == StDone);
        if (start) begin
          r_d         = init_r;
          c_d         = init_c;
          last_d      = 1'b0;
          pend_d      = 1'b0;
          pend_full_d = 1'b0;
          state_d     = StAbsorb;
        end
      end
      StAbsorb: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          if (msg_last) begin
            r_d         = r_q ^ pad_blk;
            last_d      = 1'b1;
            pend_d      = len_full | len_tight;
            pend_full_d = len_full;
          end else begin
            r_d = r_q ^ msg_data;
          end
          state_d = StPerm;
        end
      end
      StPerm: begin
        perm_req = 1'b1;
        if (perm_done) begin
          r_d = perm_r_out;
          c_d = perm_c_out;
          if (pend_q) begin
            state_d = StPad;
          end else if (last_q) begin
            state_d = StDone;
          end else begin
            state_d = StAbsorb;
          end
        end
      end
      StPad: begin
        r_d     = r_q ^ extra_blk;
        pend_d  = 1'b0;
        state_d = StPerm;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      r_q         <= '0;
      c_q         <= '0;
      last_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign perm_r_in = r_q;
  assign perm_c_in = c_q;
  assign r_out     = r_q;
  assign c_out     = c_q;

`ifdef ABSORB_BLK_COUNT_EN
  logic [15:0] cnt_q;
  logic        cnt_clr;
  logic        cnt_inc;

  assign cnt_clr = start && ((state_q == StIdle) || (state_q == StDone));
  assign cnt_inc = (state_q == StPerm) && perm_done;

  // Saturating count of completed permutations, padding-only block included.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign blk_count = cnt_q;
`else
  assign blk_count = '0;
`endif

endmodule

// File: tb/tb_sponge_absorb.sv
// Bench for sponge_absorb with a 3-cycle stub permutation
// (r -> ~r, c -> c rotated left by one).
module tb_sponge_absorb;

  localparam int RW = 32;
  localparam int CW = 320;
  localparam int LW = 6;

  logic          clk;
  logic          reset;
  logic          start;
  logic [RW-1:0] init_r;
  logic [CW-1:0] init_c;
  logic [RW-1:0] msg_data;
  logic          msg_valid;
  logic          msg_last;
  logic [LW-1:0] msg_len;
  logic          msg_ready;
  logic          perm_req;
  logic [RW-1:0] perm_r_in;
  logic [CW-1:0] perm_c_in;
  logic [RW-1:0] perm_r_out;
  logic [CW-1:0] perm_c_out;
  logic          perm_done;
  logic [RW-1:0] r_out;
  logic [CW-1:0] c_out;
  logic          absorb_done;
  logic [15:0]   blk_count;

  sponge_absorb #(.CWIDTH(CW), .RWIDTH(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .init_r     (init_r),
    .init_c     (init_c),
    .msg_data   (msg_data),
    .msg_valid  (msg_valid),
    .msg_last   (msg_last),
    .msg_len    (msg_len),
    .msg_ready  (msg_ready),
    .perm_req   (perm_req),
    .perm_r_in  (perm_r_in),
    .perm_c_in  (perm_c_in),
    .perm_r_out (perm_r_out),
    .perm_c_out (perm_c_out),
    .perm_done  (perm_done),
    .r_out      (r_out),
    .c_out      (c_out),
    .absorb_done(absorb_done),
    .blk_count  (blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub permutation.
  logic stub_done = 1'b0;
  logic late_done;
  int   stub_cnt  = 0;

  assign perm_done  = stub_done | late_done;
  assign perm_r_out = ~perm_r_in;
  assign perm_c_out = {perm_c_in[CW-2:0], perm_c_in[CW-1]};

  always @(posedge clk) begin
    if (!perm_req || stub_done) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else if (stub_cnt == 2) begin
      stub_done <= 1'b1;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  // Handshake and permutation-completion counters, cleared by start.
  int hs_cnt   = 0;
  int perm_cnt = 0;
  always @(posedge clk) begin
    if (start) begin
      hs_cnt   <= 0;
      perm_cnt <= 0;
    end else begin
      if (msg_valid && msg_ready) hs_cnt <= hs_cnt + 1;
      if (perm_req && perm_done)  perm_cnt <= perm_cnt + 1;
    end
  end

  typedef struct {
    logic [RW-1:0] ir;
    logic [CW-1:0] ic;
    int            nblk;
    logic [RW-1:0] d0;
    logic [RW-1:0] d1;
    logic [LW-1:0] len;
    logic [RW-1:0] er;
    logic [CW-1:0] ec;
    int            perms;
  } vec_t;

  typedef struct {
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    int            perms;
    int            hs;
  } exp_t;

  localparam logic [CW-1:0] CPAT  = {8'hA5, 304'h0, 8'h3C};
  localparam logic [CW-1:0] CROT1 = {8'h4A, 304'h0, 8'h79};
  localparam logic [CW-1:0] CROT2 = {8'h94, 304'h0, 8'hF2};

  vec_t vecs [8];
  exp_t sb [$];
  int   errs   = 0;
  int   checks = 0;
  logic bad_ready;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errs++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  task automatic send_block(input logic [RW-1:0] data, input logic last,
                            input logic [LW-1:0] len, output logic ok);
    msg_data  = data;
    msg_last  = last;
    msg_len   = len;
    msg_valid = 1'b1;
    ok        = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (perm_req && msg_ready) bad_ready = 1'b1;
      if (msg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("handshake");
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    logic ok;
    logic done_seen;
    e.r = v.er; e.c = v.ec; e.perms = v.perms; e.hs = v.nblk;
    sb.push_back(e);
    bad_ready = 1'b0;
    init_r    = v.ir;
    init_c    = v.ic;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_clear_on_start", CW'(absorb_done), CW'(0));
    chk("ready_after_start", CW'(msg_ready), CW'(1));
    ok = 1'b1;
    for (int b = 0; b < v.nblk && ok; b++) begin
      send_block((b == 0) ? v.d0 : v.d1, (b == v.nblk - 1), v.len, ok);
    end
    // Keep valid high with junk after the last block: it must not be taken.
    msg_data  = 32'hDEAD_0BAD;
    msg_last  = 1'b0;
    done_seen = 1'b0;
    for (int n = 0; n < 300 && ok; n++) begin
      @(negedge clk);
      if (perm_req && msg_ready) bad_ready = 1'b1;
      if (absorb_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    msg_valid = 1'b0;
    got = sb.pop_front();
    if (!done_seen) timeout("absorb_done");
    else begin
      chk("r_out", CW'(r_out), CW'(got.r));
      chk("c_out", c_out, got.c);
      chk("perm_count", CW'(perm_cnt), CW'(got.perms));
      chk("handshakes", CW'(hs_cnt), CW'(got.hs));
`ifdef ABSORB_BLK_COUNT_EN
      chk("blk_count", CW'(blk_count), CW'(got.perms));
`else
      chk("blk_count", CW'(blk_count), CW'(0));
`endif
      chk("ready_low_in_perm", CW'(bad_ready), CW'(0));
    end
  endtask

  initial begin
    logic ok;
    //           ir            ic     nblk d0            d1            len  er            ec     perms
    vecs[0] = '{32'h0,        '0,    1, 32'hAB000000, 32'h0,        6'd8,  32'h547FFFFE, '0,    1};
    vecs[1] = '{32'h0,        '0,    1, 32'hFFFFFFFF, 32'h0,        6'd0,  32'h7FFFFFFE, '0,    1};
    vecs[2] = '{32'h0,        '0,    1, 32'hFFFFFFFE, 32'h0,        6'd31, 32'hFFFFFFFE, '0,    2};
    vecs[3] = '{32'h0,        '0,    2, 32'h12345678, 32'h00000000, 6'd32, 32'h6DCBA986, '0,    3};
    vecs[4] = '{32'h0F0F0F0F, CPAT,  1, 32'hDEADBEEF, 32'h0,        6'd16, 32'h2E5D70F1, CROT1, 1};
    vecs[5] = '{32'h0,        '0,    1, 32'h55555555, 32'h0,        6'd30, 32'hAAAAAAA8, '0,    1};
    vecs[6] = '{32'h0,        CPAT,  1, 32'h80000003, 32'h0,        6'd31, 32'h80000002, CROT2, 2};
    vecs[7] = '{32'h0,        CPAT,  2, 32'hFFFFFFFF, 32'hC0000000, 6'd1,  32'h3FFFFFFE, CROT2, 2};

    reset     = 1'b1;
    start     = 1'b0;
    init_r    = '0;
    init_c    = '0;
    msg_data  = '0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_len   = '0;
    late_done = 1'b0;
    bad_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_msg_ready", CW'(msg_ready), CW'(0));
    chk("rst_perm_req", CW'(perm_req), CW'(0));
    chk("rst_absorb_done", CW'(absorb_done), CW'(0));
    chk("rst_r_out", CW'(r_out), CW'(0));
    chk("rst_c_out", c_out, CW'(0));
    chk("rst_blk_count", CW'(blk_count), CW'(0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the second cycle of a permutation.
    init_r = 32'h0F0F0F0F;
    init_c = CPAT;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_block(32'hAB000000, 1'b1, 6'd8, ok);
    msg_valid = 1'b0;
    chk("perm_req_before_reset", CW'(perm_req), CW'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_perm_req", CW'(perm_req), CW'(0));
    chk("midrst_msg_ready", CW'(msg_ready), CW'(0));
    chk("midrst_absorb_done", CW'(absorb_done), CW'(0));
    chk("midrst_r_out", CW'(r_out), CW'(0));
    chk("midrst_c_out", c_out, CW'(0));
    // A stray perm_done in IDLE must not load the permutation outputs.
    late_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    late_done = 1'b0;
    chk("late_done_perm_req", CW'(perm_req), CW'(0));
    chk("late_done_r_out", CW'(r_out), CW'(0));
    chk("late_done_absorb_done", CW'(absorb_done), CW'(0));

    run_vec(vecs[0]);
    run_vec(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sponge_absorb.md
Name: sponge_absorb

Overview:
- Absorb phase of the sponge construction; writer-side counterpart to the squeeze block.
- Accepts message blocks of RWIDTH bits over a valid/ready stream and XORs each into the rate register.
- Applies pad10*1 on the final block and runs the external G permutation after every absorbed block.
- Presents the final rate/capacity (r_out, c_out) with absorb_done, ready to feed the squeeze block's r and c inputs.

Parameters:
- CWIDTH, 320, capacity width in bits.
- RWIDTH, 32, rate/block width in bits (>=2).
- LENW, $clog2(RWIDTH+1), width of msg_len (localparam, derived).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse in IDLE; loads init_r/init_c and begins absorbing.
- init_r  input  RWIDTH  initial rate value.
- init_c  input  CWIDTH  initial capacity value.
- msg_data  input  RWIDTH  message block, MSB-aligned.
- msg_valid  input  1  block present.
- msg_last  input  1  final block of the message.
- msg_len  input  LENW  valid bits in the last block, 0..RWIDTH; ignored when msg_last=0.
- msg_ready  output  1  block accepted when msg_valid&msg_ready.
- perm_req  output  1  permutation request, held until perm_done.
- perm_r_in  output  RWIDTH  rate to permutation.
- perm_c_in  output  CWIDTH  capacity to permutation.
- perm_r_out  input  RWIDTH  permuted rate.
- perm_c_out  input  CWIDTH  permuted capacity.
- perm_done  input  1  permutation result valid.
- r_out  output  RWIDTH  final rate.
- c_out  output  CWIDTH  final capacity.
- absorb_done  output  1  r_out/c_out valid.
- blk_count  output  16  absorbed-block counter (see Optional Feature).

Behaviour:
- Reset (synchronous): state IDLE. msg_ready, perm_req, absorb_done = 0. Internal r/c registers = 0, so r_out, c_out = 0. blk_count = 0. Applies mid-operation too; perm_req drops on the same edge.
- States: IDLE, ABSORB, PERM, PAD, DONE.
- IDLE: on start, r<=init_r, c<=init_c, go to ABSORB. Next cycle msg_ready=1. start is ignored in PERM and PAD.
- ABSORB: msg_ready=1, combinationally, only in this state.
  - Handshake accepted, msg_last=0: r <= r ^ msg_data, go to PERM.
  - Handshake accepted, msg_last=1: build padded block P. Bits [RWIDTH-1 -: msg_len] come from msg_data; all lower data bits are forced to 0.
  - len <= RWIDTH-2: P = data | (1 << (RWIDTH-1-len)) | 1.
  - len = RWIDTH-1: P = data | 1, and an extra block 0...01 is pending.
  - len = RWIDTH: P = data, and an extra block 10...01 is pending.
  - In all last-block cases: r <= r ^ P, set last_seen, go to PERM.
- PERM: perm_req=1; perm_r_in=r and perm_c_in=c are held stable. On the first edge with perm_done=1: r<=perm_r_out, c<=perm_c_out, and perm_req deasserts the next cycle. Then:
  - extra block pending -> PAD.
  - else last_seen -> DONE.
  - else -> ABSORB.
- perm_done is ignored while perm_req=0. Minimum turnaround: one cycle in PERM when perm_done is already high.
- PAD: r <= r ^ extra block, clear pending, go to PERM (one cycle).
- DONE: absorb_done=1; r_out/c_out hold the final registers (they always mirror the internal registers). A start pulse reloads init and re-enters ABSORB. absorb_done clears on that edge.
- msg_valid with msg_ready=0 is not consumed, and msg_data may change freely while it waits.

Optional Feature:
- Macro: ABSORB_BLK_COUNT_EN.
- Defined: blk_count increments (saturating at 16'hFFFF) on each permutation completion, including the padding-only block. It clears on start and on reset.
- Undefined: blk_count is tied to 0 and no counter logic is built.

Test Plan:
- Stub permutation for all scenarios: 3-cycle latency, perm_r_out=~perm_r_in, perm_c_out=perm_c_in rotated left 1. Defaults RWIDTH=32, CWIDTH=320, init all-zero.
- Single last block, data 0xAB000000, len 8 -> one perm request; r_out=~0xAB800001=0x547FFFFE, c_out=0, absorb_done=1, blk_count=1 (macro on).
- Empty message, len 0 -> P=0x80000001; r_out=0x7FFFFFFE, one perm.
- Last block 0xFFFFFFFE, len 31 -> two perms (P=0xFFFFFFFF, then extra 0x00000001); r_out=0xFFFFFFFE, blk_count=2.
- Two blocks: 0x12345678 (not last), then full len 32 block 0x00000000 -> three perms total; blk_count=3; msg_ready low during each PERM, msg_valid held high is not double-accepted.
- Reset asserted during PERM (cycle 2 of stub latency) -> next cycle perm_req=0, msg_ready=0, absorb_done=0, r_out=c_out=0. A late perm_done is ignored; a fresh start absorbs correctly.
- Build without ABSORB_BLK_COUNT_EN, rerun the two-block case -> blk_count stays 0, r_out/c_out identical to the macro-on run.
